// File: rtl/instr_encoder_loader_if.sv
// Request channel of the instruction encoder/loader: field-level instruction requests.
// A transfer happens on every rising clk edge where req_valid and req_ready are both 1; the master holds its fields stable while req_valid=1 and req_ready=0.
interface instr_encoder_loader_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_class;
  logic [3:0] req_sub;
  logic [2:0] req_rd;
  logic [2:0] req_ra;
  logic [2:0] req_rb;
  logic [6:0] req_imm;

  modport master (
    output req_valid, req_class, req_sub, req_rd, req_ra, req_rb, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_class, req_sub, req_rd, req_ra, req_rb, req_imm,
    output req_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs field-level requests into 16-bit ISA words and writes them sequentially into imem.
// Optional macro ENC_CHECK_EN: reject class 11 and out-of-range LI immediates with an enc_err pulse.
module instr_encoder_loader #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [AW-1:0]           start_addr,
  instr_encoder_loader_if.slave   req,
  output logic                    imem_we,
  output logic [AW-1:0]           imem_addr,
  output logic [15:0]             imem_wdata,
  output logic                    full,
  output logic [AW:0]             word_count,
  output logic                    enc_err,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wdata;
  logic          r_err;

  logic          w_accept;
  logic          w_reject;
  logic          w_write;
  logic          w_is_li;
  logic [15:0]   w_enc;
  logic [AW:0]   w_count_nxt;

  assign full          = (r_state == S_FULL);
  assign req.req_ready = (r_state == S_RUN) && !full && !load_start;
  assign w_accept      = req.req_valid && req.req_ready;
  assign w_is_li       = (req.req_class == 2'b01) && (req.req_sub == 4'b1010);
  assign w_count_nxt   = r_count + 1'b1;

`ifdef ENC_CHECK_EN
  assign w_reject = (req.req_class == 2'b11) || (w_is_li && req.req_imm[6]);
`else
  assign w_reject = 1'b0;
`endif

  assign w_write = w_accept && !w_reject;

  always_comb begin
    w_enc = 16'h0000;
    case (req.req_class)
      2'b00: w_enc = {2'b00, req.req_sub[0], req.req_rd, req.req_ra, req.req_imm};
      2'b01: begin
        if (w_is_li)
          w_enc = {2'b01, 4'b1010, 1'b0, req.req_rd, req.req_imm[5:0]};
        else
          w_enc = {2'b01, req.req_sub, 1'b0, req.req_rd, req.req_ra, req.req_rb};
      end
      2'b10: begin
        case (req.req_sub[2:0])
          3'b110:  w_enc = {2'b10, 3'b110, 6'b0, req.req_rd, 2'b00};
          3'b111:  w_enc = {2'b10, 3'b111, 11'b0};
          default: w_enc = {2'b10, req.req_sub[2:0], req.req_ra, req.req_rb, req.req_rd, 2'b00};
        endcase
      end
      default: w_enc = 16'hC000;
    endcase
  end

  // word_count advances with the write strobe so full drops req_ready before an extra accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      r_we  <= w_write;
      r_err <= w_accept && w_reject;
      if (w_write) begin
        r_addr  <= r_ptr;
        r_wdata <= w_enc;
      end
      if (load_start) begin
        r_state <= S_RUN;
        r_ptr   <= start_addr;
        r_count <= '0;
      end else if (w_write) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= w_count_nxt;
        if (w_count_nxt == DEPTH_C)
          r_state <= S_FULL;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_count;
  assign enc_err    = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized requests against a field-level model.
module tb_instr_encoder_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW-1:0] start_addr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          full;
  logic [AW:0]   word_count;
  logic          enc_err;
  logic [1:0]    dbg_state;

  instr_encoder_loader_if bus ();

  instr_encoder_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .start_addr(start_addr),
    .req(bus.slave), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .full(full), .word_count(word_count), .enc_err(enc_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [AW+15:0] exp_q[$];
  logic [AW-1:0]  m_ptr = '0;
  int             m_count = 0;
  logic           m_err_flag = 1'b0;

  // Reference encoder written as field weights of the 16-bit word.
  function automatic logic [15:0] ref_encode(input logic [1:0] c, input logic [3:0] s,
                                             input logic [2:0] rd, input logic [2:0] ra,
                                             input logic [2:0] rb, input logic [6:0] imm);
    int w;
    int cond;
    w = 0;
    cond = int'(s) % 8;
    case (c)
      2'd0: w = int'(s[0]) * 8192 + int'(rd) * 1024 + int'(ra) * 128 + int'(imm);
      2'd1: begin
        if (s == 4'd10) w = 16384 + 10 * 1024 + int'(rd) * 64 + int'(imm) % 64;
        else            w = 16384 + int'(s) * 1024 + int'(rd) * 64 + int'(ra) * 8 + int'(rb);
      end
      2'd2: begin
        if (cond == 7)      w = 32768 + 7 * 2048;
        else if (cond == 6) w = 32768 + 6 * 2048 + int'(rd) * 4;
        else                w = 32768 + cond * 2048 + int'(ra) * 256 + int'(rb) * 32 + int'(rd) * 4;
      end
      default: w = 49152;
    endcase
    return w[15:0];
  endfunction

  function automatic bit ref_reject(input logic [1:0] c, input logic [3:0] s, input logic [6:0] imm);
`ifdef ENC_CHECK_EN
    return (c == 2'd3) || (c == 2'd1 && s == 4'd10 && imm >= 7'd64);
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: every write must match the oldest expected {addr,data}; enc_err must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got addr=%0h data=%0h, required no write", imem_addr, imem_wdata);
        end else begin
          logic [AW+15:0] e;
          e = exp_q.pop_front();
          if ({imem_addr, imem_wdata} !== e) begin
            errors++;
            $display("FAIL sb_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     imem_addr, imem_wdata, e[AW+15:16], e[15:0]);
          end
        end
      end
      checks++;
      if (enc_err !== m_err_flag) begin
        errors++;
        $display("FAIL sb_enc_err: got %0b, required %0b", enc_err, m_err_flag);
      end
      m_err_flag = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [AW-1:0] a);
    load_start = 1'b1;
    start_addr = a;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    m_ptr = a;
    m_count = 0;
  endtask

  // Drives one request until accepted (bounded), then updates the model.
  task automatic send(input logic [1:0] c, input logic [3:0] s, input logic [2:0] rd,
                      input logic [2:0] ra, input logic [2:0] rb, input logic [6:0] imm);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_class = c; bus.req_sub = s; bus.req_rd = rd;
    bus.req_ra = ra; bus.req_rb = rb; bus.req_imm = imm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
    #1;
    bus.req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no accept in 20 cycles, required accept");
    end else if (ref_reject(c, s, imm)) begin
      m_err_flag = 1'b1;
    end else begin
      exp_q.push_back({m_ptr, ref_encode(c, s, rd, ra, rb, imm)});
      m_ptr = m_ptr + 1'b1;
      m_count++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; start_addr = '0;
    bus.req_valid = 1'b0; bus.req_class = '0; bus.req_sub = '0;
    bus.req_rd = '0; bus.req_ra = '0; bus.req_rb = '0; bus.req_imm = '0;
    #12;
    checks++;
    if ({imem_we, imem_addr, imem_wdata, word_count, full, enc_err, bus.req_ready, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_values: got we=%0b addr=%0h data=%0h cnt=%0d full=%0b err=%0b rdy=%0b st=%0d, required all 0",
               imem_we, imem_addr, imem_wdata, word_count, full, enc_err, bus.req_ready, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_not_ready: got req_ready=%0b, required 0", bus.req_ready);
    end
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    do_load(8'h10);
    send(2'd0, 4'd0, 3'd3, 3'd2, 3'd0, 7'd5);
    checks++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h10, 16'h0D05}) begin
      errors++;
      $display("FAIL basic_ld: got we=%0b addr=%0h data=%0h, required we=1 addr=10 data=0d05", imem_we, imem_addr, imem_wdata);
    end
    idle(2);
    checks++;
    if (word_count !== 9'd1) begin
      errors++;
      $display("FAIL basic_count: got %0d, required 1", word_count);
    end
  endtask

  task automatic test_back_to_back();
    do_load(8'h10);
    send(2'd0, 4'd1, 3'd1, 3'd7, 3'd0, 7'h7F);
    checks++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h10, 16'h27FF}) begin
      errors++;
      $display("FAIL b2b_first: got we=%0b addr=%0h data=%0h, required we=1 addr=10 data=27ff", imem_we, imem_addr, imem_wdata);
    end
    send(2'd1, 4'd3, 3'd5, 3'd1, 3'd2, 7'd0);
    checks++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h11, 16'h4D4A}) begin
      errors++;
      $display("FAIL b2b_second: got we=%0b addr=%0h data=%0h, required we=1 addr=11 data=4d4a", imem_we, imem_addr, imem_wdata);
    end
    idle(2);
  endtask

  task automatic test_encodings();
    do_load(8'h30);
    send(2'd1, 4'd10, 3'd4, 3'd0, 3'd0, 7'h2A);
    checks++;
    if (imem_wdata !== 16'h692A) begin
      errors++;
      $display("FAIL enc_li: got %0h, required 692a", imem_wdata);
    end
    send(2'd2, 4'd6, 3'd6, 3'd3, 3'd0, 7'd0);
    checks++;
    if (imem_wdata !== 16'hB018) begin
      errors++;
      $display("FAIL enc_jmp110: got %0h, required b018", imem_wdata);
    end
    send(2'd2, 4'd7, 3'd5, 3'd4, 3'd3, 7'd9);
    checks++;
    if (imem_wdata !== 16'hB800) begin
      errors++;
      $display("FAIL enc_nop: got %0h, required b800", imem_wdata);
    end
    send(2'd3, 4'd5, 3'd1, 3'd2, 3'd3, 7'd4);
    checks++;
`ifdef ENC_CHECK_EN
    if ({enc_err, imem_we, word_count} !== {1'b1, 1'b0, 9'd3}) begin
      errors++;
      $display("FAIL enc_rsv_check: got err=%0b we=%0b cnt=%0d, required err=1 we=0 cnt=3", enc_err, imem_we, word_count);
    end
`else
    if ({imem_we, imem_wdata, word_count} !== {1'b1, 16'hC000, 9'd4}) begin
      errors++;
      $display("FAIL enc_rsv: got we=%0b data=%0h cnt=%0d, required we=1 data=c000 cnt=4", imem_we, imem_wdata, word_count);
    end
`endif
    idle(2);
  endtask

  task automatic test_full();
    do_load(8'hFD);
    for (int i = 0; i < DEPTH; i++)
      send(2'd0, 4'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'd0, 7'(i));
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_held: got req_ready=%0b, required 0", bus.req_ready);
      end
    end
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({full, word_count, dbg_state} !== {1'b1, 9'(DEPTH), 2'd2}) begin
      errors++;
      $display("FAIL full_state: got full=%0b cnt=%0d st=%0d, required full=1 cnt=%0d st=2", full, word_count, dbg_state, DEPTH);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain: got %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_load_restart();
    do_load(8'h80);
    send(2'd1, 4'd2, 3'd1, 3'd2, 3'd3, 7'd0);
    bus.req_valid = 1'b1;
    bus.req_class = 2'd0; bus.req_sub = 4'd0; bus.req_rd = 3'd7;
    bus.req_ra = 3'd6; bus.req_rb = 3'd0; bus.req_imm = 7'h55;
    load_start = 1'b1;
    start_addr = 8'h40;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_priority: got req_ready=%0b, required 0", bus.req_ready);
    end
    @(posedge clk);
    #1;
    load_start = 1'b0;
    m_ptr = 8'h40;
    m_count = 0;
    checks++;
    if ({word_count, imem_we} !== {9'd0, 1'b0}) begin
      errors++;
      $display("FAIL restart_clear: got cnt=%0d we=%0b, required cnt=0 we=0", word_count, imem_we);
    end
    send(2'd0, 4'd0, 3'd7, 3'd6, 3'd0, 7'h55);
    checks++;
    if ({imem_we, imem_addr} !== {1'b1, 8'h40}) begin
      errors++;
      $display("FAIL restart_addr: got we=%0b addr=%0h, required we=1 addr=40", imem_we, imem_addr);
    end
    idle(2);
  endtask

  task automatic test_random();
    do_load(8'($urandom));
    for (int i = 0; i < 60; i++) begin
      if (m_count == DEPTH) begin
        idle(1);
        do_load(8'($urandom));
      end
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom),
           3'($urandom), 7'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    checks++;
    if (word_count !== 9'(m_count)) begin
      errors++;
      $display("FAIL random_count: got %0d, required %0d", word_count, m_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_load(8'h20);
    send(2'd1, 4'd5, 3'd2, 3'd3, 3'd4, 7'd0);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_err_flag = 1'b0;
    checks++;
    if ({imem_we, imem_addr, imem_wdata, word_count, full, enc_err, bus.req_ready, dbg_state} !== '0) begin
      errors++;
      $display("FAIL async_reset: got we=%0b addr=%0h data=%0h cnt=%0d full=%0b err=%0b rdy=%0b st=%0d, required all 0",
               imem_we, imem_addr, imem_wdata, word_count, full, enc_err, bus.req_ready, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_encodings();
    test_full();
    test_load_restart();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
